// File: rtl/fifo_drain_sched.sv
// fifo_drain_sched: round-robin drain scheduler for a bank of FIFOs.
// Grants one channel at a time for a burst of at most BURST_LEN pops. Each
// popped word is captured one cycle later together with its channel id. The
// word then goes through a 2-entry output FIFO that feeds a valid/ready stream.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   en          global enable; low blocks new pops
//   ch_en       per-channel enable mask
//   fifo_out    packed read data, channel i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   fifo_empty  per-channel empty flags
//   fifo_pop    one-hot pop strobes to the bank
//   m_data      output word, with m_chan as its source channel
//   m_valid     output valid; m_ready is the downstream accept
//   busy        grant active, pop in flight, or output FIFO non-empty
module fifo_drain_sched #(
  parameter int N_DTPS     = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CH_W       = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_DTPS-1:0]            ch_en,
  input  logic [N_DTPS*FIFO_WIDTH-1:0] fifo_out,
  input  logic [N_DTPS-1:0]            fifo_empty,
  output logic [N_DTPS-1:0]            fifo_pop,
  output logic [FIFO_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_chan,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_n;
  logic [CH_W-1:0]       rr_ptr, rr_n;
  logic [CH_W-1:0]       grant_ch, grant_n;
  logic [CNT_W-1:0]      burst_cnt, burst_n;
  logic [CH_W-1:0]       arb_ch;
  logic                  arb_found;
  logic                  grant_elig;
  logic [N_DTPS-1:0]     elig;
  logic [N_DTPS-1:0]     pop_vec;
  logic                  inflight;
  logic [CH_W-1:0]       inflight_ch;
  logic [FIFO_WIDTH-1:0] cap_data;
  logic [FIFO_WIDTH-1:0] slot1_data;
  logic [CH_W-1:0]       slot1_chan;
  logic                  slot1_valid;
  logic                  xfer;
  logic [1:0]            occ;
  logic                  space_ok;

  assign elig     = ch_en & ~fifo_empty;
  assign xfer     = m_valid & m_ready;
  // Occupancy counts the in-flight word, so a pop is only issued when its
  // capture slot is guaranteed one cycle later.
  assign occ      = 2'(m_valid) + 2'(slot1_valid) + 2'(inflight);
  assign space_ok = (occ - 2'(xfer)) < 2'd2;
  assign grant_elig = |(elig & (N_DTPS'(1) << grant_ch));

  // Cyclic first-eligible search from rr_ptr: channels at or above the pointer
  // win first, then the wrapped-around lower channels.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int unsigned i = 0; i < N_DTPS; i++) begin
      if (!arb_found && elig[i] && (CH_W'(i) >= rr_ptr)) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_DTPS; i++) begin
      if (!arb_found && elig[i]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_ch;
    burst_n = burst_cnt;
    rr_n    = rr_ptr;
    pop_vec = '0;
    case (state)
      IDLE: begin
        if (en && arb_found) begin
          grant_n = arb_ch;
          state_n = GRANT;
          burst_n = '0;
          // Arbitration and first pop share this cycle when space allows.
          if (space_ok) begin
            pop_vec = N_DTPS'(1) << arb_ch;
            burst_n = CNT_W'(1);
          end
        end
      end
      GRANT: begin
        if (!en || !grant_elig || (burst_cnt == CNT_W'(BURST_LEN))) begin
          state_n = IDLE;
          rr_n    = (grant_ch == CH_W'(N_DTPS - 1)) ? '0 : grant_ch + 1'b1;
        end else if (space_ok) begin
          pop_vec = N_DTPS'(1) << grant_ch;
          burst_n = burst_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gated so that no pop escapes while reset is asserted.
  assign fifo_pop = rst ? '0 : pop_vec;
  assign busy     = (state == GRANT) | inflight | m_valid;

  always_comb begin
    cap_data = '0;
    for (int unsigned i = 0; i < N_DTPS; i++) begin
      if (inflight_ch == CH_W'(i)) cap_data = fifo_out[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_ch    <= '0;
      burst_cnt   <= '0;
      inflight    <= 1'b0;
      inflight_ch <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_n;
      grant_ch    <= grant_n;
      burst_cnt   <= burst_n;
      inflight    <= |pop_vec;
      inflight_ch <= grant_n;
    end
  end

  // Two-entry output FIFO: head is the m_* registers, slot1 sits behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_chan      <= '0;
      slot1_valid <= 1'b0;
      slot1_data  <= '0;
      slot1_chan  <= '0;
    end else if (xfer) begin
      if (slot1_valid) begin
        m_data      <= slot1_data;
        m_chan      <= slot1_chan;
        slot1_valid <= inflight;
        if (inflight) begin
          slot1_data <= cap_data;
          slot1_chan <= inflight_ch;
        end
      end else if (inflight) begin
        m_data <= cap_data;
        m_chan <= inflight_ch;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (inflight) begin
      if (!m_valid) begin
        m_valid <= 1'b1;
        m_data  <= cap_data;
        m_chan  <= inflight_ch;
      end else begin
        slot1_valid <= 1'b1;
        slot1_data  <= cap_data;
        slot1_chan  <= inflight_ch;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Directed testbench for fifo_drain_sched with a behavioural FIFO bank
// (data one cycle after pop, empty reflecting pops up to the previous cycle).
module tb_fifo_drain_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 2;
  localparam int BL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   ch_en;
  logic [N*W-1:0] fifo_out;
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   fifo_pop;
  logic [W-1:0]   m_data;
  logic [CW-1:0]  m_chan;
  logic           m_valid;
  logic           m_ready;
  logic           busy;

  always #5 clk = ~clk;

  fifo_drain_sched #(.N_DTPS(N), .FIFO_WIDTH(W), .CH_W(CW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .fifo_out(fifo_out),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .m_data(m_data),
    .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  // FIFO bank model
  logic [W-1:0] mem [N][64];
  logic [5:0]   wr_ptr [N] = '{default: '0};
  logic [5:0]   rd_ptr [N] = '{default: '0};
  logic [W-1:0] fout   [N] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_pop[i]) begin
        fout[i]   <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 6'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_out[i*W +: W] = fout[i];
      fifo_empty[i]      = (wr_ptr[i] == rd_ptr[i]);
    end
  end

  // Monitor: logs pops and transfers, flags protocol violations
  int            cyc = 0;
  int            pop_ch_q[$];
  int            pop_cyc_q[$];
  logic [W-1:0]  out_d_q[$];
  logic [CW-1:0] out_c_q[$];
  int            viol = 0;
  logic          hold = 1'b0;
  logic [W-1:0]  hold_d = '0;
  logic [CW-1:0] hold_c = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    int bad;
    bad = 0;
    if (rst) begin
      hold <= 1'b0;
    end else begin
      if (fifo_pop != '0) begin
        if (!$onehot(fifo_pop) || ((fifo_pop & fifo_empty) != '0)) bad = bad + 1;
        for (int i = N - 1; i >= 0; i--) begin
          if (fifo_pop[i]) begin
            pop_ch_q.push_back(i);
            pop_cyc_q.push_back(cyc);
            break;
          end
        end
      end
      if (hold && (!m_valid || (m_data != hold_d) || (m_chan != hold_c))) bad = bad + 1;
      if (m_valid && m_ready) begin
        out_d_q.push_back(m_data);
        out_c_q.push_back(m_chan);
      end
      hold   <= m_valid && !m_ready;
      hold_d <= m_data;
      hold_c <= m_chan;
    end
    viol <= viol + bad;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [W-1:0] d);
    mem[ch][wr_ptr[ch]] = d;
    wr_ptr[ch] = wr_ptr[ch] + 6'd1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < max_cyc) begin
      step();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check({tag, "_idle"}, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_pops(input string tag, input int base, input int ech[$]);
    int got_n = pop_ch_q.size() - base;
    check({tag, "_npops"}, 32'(got_n), 32'(ech.size()));
    for (int k = 0; k < ech.size() && k < got_n; k++)
      check($sformatf("%s_pop%0d", tag, k), 32'(pop_ch_q[base + k]), 32'(ech[k]));
  endtask

  task automatic check_out(input string tag, input int base,
                           input logic [W-1:0] ed[$], input int ec[$]);
    int got_n = out_d_q.size() - base;
    check({tag, "_nwords"}, 32'(got_n), 32'(ed.size()));
    for (int k = 0; k < ed.size() && k < got_n; k++) begin
      check($sformatf("%s_data%0d", tag, k), 32'(out_d_q[base + k]), 32'(ed[k]));
      check($sformatf("%s_chan%0d", tag, k), 32'(out_c_q[base + k]), 32'(ec[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, o, p2, o2;
    int ech[$];
    int ec[$];
    logic [W-1:0] ed[$];

    rst = 1'b1; en = 1'b0; ch_en = 4'b1111; m_ready = 1'b1;
    step(); step();
    check("rst_pop",   32'(fifo_pop), 32'd0);
    check("rst_valid", 32'(m_valid),  32'd0);
    check("rst_data",  32'(m_data),   32'd0);
    check("rst_chan",  32'(m_chan),   32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    rst = 1'b0;
    step();

    // Single channel, 6 words, burst of 4 then re-grant after a pointer wrap
    for (int j = 0; j < 6; j++) load(0, W'(16'hA000 + j));
    p = pop_ch_q.size(); o = out_d_q.size();
    en = 1'b1;
    wait_idle("single", 100);
    en = 1'b0;
    ech = '{0, 0, 0, 0, 0, 0};
    check_pops("single", p, ech);
    if (pop_cyc_q.size() >= p + 6) begin
      check("single_gap1", 32'(pop_cyc_q[p+1] - pop_cyc_q[p]),   32'd1);
      check("single_gap2", 32'(pop_cyc_q[p+2] - pop_cyc_q[p+1]), 32'd1);
      check("single_gap3", 32'(pop_cyc_q[p+3] - pop_cyc_q[p+2]), 32'd1);
      check("single_gap4", 32'(pop_cyc_q[p+4] - pop_cyc_q[p+3]), 32'd2);
      check("single_gap5", 32'(pop_cyc_q[p+5] - pop_cyc_q[p+4]), 32'd1);
    end
    ed = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    ec = '{0, 0, 0, 0, 0, 0};
    check_out("single", o, ed, ec);
    check("single_busy", 32'(busy), 32'd0);

    // Round robin from pointer 0 after reset
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) load(i, W'(16'hB000 + i * 16 + j));
    p = pop_ch_q.size(); o = out_d_q.size();
    en = 1'b1;
    wait_idle("rr", 100);
    en = 1'b0;
    ech = '{0, 0, 1, 1, 2, 2, 3, 3};
    check_pops("rr", p, ech);
    ed = '{16'hB000, 16'hB001, 16'hB010, 16'hB011, 16'hB020, 16'hB021, 16'hB030, 16'hB031};
    check_out("rr", o, ed, ech);

    // Backpressure: pointer is 0, ch1 is the only loaded channel
    for (int j = 0; j < 6; j++) load(1, W'(16'hD010 + j));
    p = pop_ch_q.size(); o = out_d_q.size();
    m_ready = 1'b0; en = 1'b1;
    repeat (5) step();
    check("bp_pops_le2", (pop_ch_q.size() - p <= 2) ? 32'd1 : 32'd0, 32'd1);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data",  32'(m_data),  32'hD010);
    check("bp_chan",  32'(m_chan),  32'd1);
    m_ready = 1'b1;
    wait_idle("bp", 100);
    en = 1'b0;
    ed = '{16'hD010, 16'hD011, 16'hD012, 16'hD013, 16'hD014, 16'hD015};
    ec = '{1, 1, 1, 1, 1, 1};
    check_out("bp", o, ed, ec);

    // Empty mid-burst; ch1 re-grant above left the pointer at 2
    load(2, 16'hE020);
    for (int j = 0; j < 3; j++) load(3, W'(16'hE030 + j));
    p = pop_ch_q.size(); o = out_d_q.size();
    en = 1'b1;
    wait_idle("empty", 100);
    en = 1'b0;
    ech = '{2, 3, 3, 3};
    check_pops("empty", p, ech);
    if (pop_cyc_q.size() >= p + 2)
      check("empty_handoff", 32'(pop_cyc_q[p+1] - pop_cyc_q[p]), 32'd2);
    ed = '{16'hE020, 16'hE030, 16'hE031, 16'hE032};
    check_out("empty", o, ed, ech);

    // Masking: only channels 1 and 3 enabled
    ch_en = 4'b1010;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) load(i, W'(16'hF000 + i * 16 + j));
    p = pop_ch_q.size(); o = out_d_q.size();
    en = 1'b1;
    wait_idle("mask", 100);
    en = 1'b0;
    ech = '{1, 1, 3, 3};
    check_pops("mask", p, ech);
    ed = '{16'hF010, 16'hF011, 16'hF030, 16'hF031};
    check_out("mask", o, ed, ech);

    // en dropped after the first pop: in-flight word still delivered
    ch_en = 4'b1111;
    p = pop_ch_q.size(); o = out_d_q.size();
    en = 1'b1;
    step();
    en = 1'b0;
    wait_idle("endrop", 100);
    ech = '{0};
    check_pops("endrop", p, ech);
    ed = '{16'hF000};
    check_out("endrop", o, ed, ech);

    // Reset between pop and capture; pointer is 1 so ch2 is popped first
    p = pop_ch_q.size();
    en = 1'b1;
    step();
    ech = '{2};
    check_pops("rstmid_pre", p, ech);
    rst = 1'b1;
    #1;
    check("rstmid_pop",   32'(fifo_pop), 32'd0);
    check("rstmid_valid", 32'(m_valid),  32'd0);
    check("rstmid_data",  32'(m_data),   32'd0);
    check("rstmid_chan",  32'(m_chan),   32'd0);
    check("rstmid_busy",  32'(busy),     32'd0);
    step(); step();
    p2 = pop_ch_q.size(); o2 = out_d_q.size();
    rst = 1'b0;
    wait_idle("rstmid", 100);
    en = 1'b0;
    ech = '{0, 2};
    check_pops("rstmid_post", p2, ech);
    ed = '{16'hF001, 16'hF021};
    check_out("rstmid_post", o2, ed, ech);

    check("monitor_viol", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_drain_sched.md
Name: fifo_drain_sched

Overview:
- Round-robin drain scheduler for a bank of N_DTPS FIFOs.
- Issues one-hot pops to the bank and captures returned words with their channel id.
- Presents words on a single valid/ready output stream for the downstream packer.
- Sustains 1 word/cycle and holds a granted channel for a bounded burst.

Parameters:
- N_DTPS, 4: number of FIFO channels.
- FIFO_WIDTH, 16: data width per channel.
- CH_W, 2: channel-id width; must satisfy 2^CH_W >= N_DTPS.
- BURST_LEN, 4: maximum consecutive pops per grant, >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; 0 blocks new pops.
- ch_en  input  N_DTPS  per-channel enable mask.
- fifo_out  input  N_DTPS*FIFO_WIDTH  FIFO read data; channel i is in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- fifo_empty  input  N_DTPS  FIFO empty flags.
- fifo_pop  output  N_DTPS  pop strobes, at most one bit high per cycle.
- m_data  output  FIFO_WIDTH  output word.
- m_chan  output  CH_W  source channel of m_data.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- busy  output  1  high when a grant is active, a pop is in flight, or the buffer holds data.

Behaviour:
- Reset (async assert, sync release): fifo_pop=0, m_valid=0, m_data=0, m_chan=0, busy=0, rr pointer=0, grant idle, burst counter=0, in-flight flag=0, buffer empty. Reset mid-operation discards in-flight and buffered words with no further pops.
- FIFO contract: read data for a pop in cycle t is valid on fifo_out in cycle t+1. fifo_empty reflects all pops issued through cycle t-1, so back-to-back pops on one channel are legal.
- Eligible channel i: ch_en[i]=1 and fifo_empty[i]=0.
- FSM IDLE:
  - If en=1 and any channel is eligible, grant the first eligible channel at or after the rr pointer, cyclically.
  - Set burst counter=0 and go to GRANT.
  - Arbitration and the first pop may occur in the same cycle.
- FSM GRANT:
  - Pop the granted channel when all hold: en=1; the channel is eligible; space is available; burst counter < BURST_LEN.
  - Space rule: (buf_count + inflight - (m_valid & m_ready)) < 2.
  - Each pop increments the burst counter.
  - Leave GRANT when: the burst counter reaches BURST_LEN; the granted channel is non-eligible; or en=0.
  - On leaving, set the rr pointer to granted+1 mod N_DTPS and go to IDLE. Pointer wrap is N_DTPS-1 -> 0.
  - Blocked only by space: stay in GRANT with no pop and the counter unchanged.
- Capture path:
  - A 1-cycle in-flight register holds the popped channel id.
  - In cycle t+1 the word from fifo_out[id] and its id are written to a 2-entry output FIFO.
  - The output FIFO head drives m_data/m_chan/m_valid.
  - Push and pop of the output FIFO in the same cycle are legal.
  - The space rule guarantees the output FIFO never overflows.
- Output handshake:
  - A word transfers when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_chan hold stable.
  - m_valid never drops without a transfer, except on reset.
- en=0 mid-burst: no new pops; any in-flight word is still captured and delivered.
- ch_en[i] cleared mid-burst: treated as non-eligible from that cycle.
- Throughput: with m_ready=1 and data available, one pop per cycle within a burst. The handoff to the next channel costs one arbitration cycle (pop-less), unless the same-cycle arbitration path applies.
- Ordering: words from one channel are delivered in pop order. m_chan always equals the source channel.

Test Plan:
- Single channel: ch0 holds A0..A5, BURST_LEN=4, m_ready=1 -> fifo_pop[0] high 4 consecutive cycles; ch0 re-granted after the pointer wraps with no other eligible channel; 6 words A0..A5 out with m_chan=0; busy falls after the last transfer.
- Round-robin: ch0..ch3 each hold 2 words -> grant order 0,1,2,3; output order c0w0,c0w1,c1w0,c1w1,...; m_chan sequence 0,0,1,1,2,2,3,3.
- Backpressure: continuous data, m_ready=0 for 5 cycles -> at most 2 pops issued; m_data stable; no word lost or duplicated after m_ready=1.
- Empty mid-burst: ch2 holds 1 word, ch3 holds 3 words, pointer=2 -> one pop on ch2, then grant moves to ch3 and 3 pops follow.
- Masking and enable: ch_en=4'b1010, all channels non-empty -> only channels 1 and 3 popped. Drop en during a pop -> the in-flight word is still delivered and no further fifo_pop occurs.
- Async reset asserted between pop and capture -> all outputs 0 immediately; after release, the first grant goes to channel 0.
